// File: rtl/fir_fixed_top.sv
// fir_fixed_top: decimating fixed-point FIR reconstruction for a control-bounded ADC.
// The estimate covers the window that includes the sample being taken this edge.
package Coefficients_Fx;
  localparam int N = 1;
  localparam int LA = 220;
  localparam int LB = 220;
  localparam int W = 24;
  typedef logic [N-1:0][LA-1:0][W-1:0] hf_t;
  typedef logic [N-1:0][LB-1:0][W-1:0] hb_t;
  function automatic hf_t gen_hf();
    hf_t t;
    for (int c = 0; c < N; c++)
      for (int i = 0; i < LA; i++)
        t[c][i] = W'((i % 2 == 1 ? -1 : 1) * ((1 << 18) / (i + 1)));
    return t;
  endfunction
  function automatic hb_t gen_hb();
    hb_t t;
    for (int c = 0; c < N; c++)
      for (int i = 0; i < LB; i++)
        t[c][i] = W'((i % 2 == 1 ? 1 : -1) * ((1 << 17) / (i + 1)));
    return t;
  endfunction
  localparam hf_t hf = gen_hf();
  localparam hb_t hb = gen_hb();
endpackage

module fir_fixed_top #(
  parameter int Lookahead = 220,
  parameter int Lookback = 220,
  parameter int OSR = 1,
  parameter int n_int = 4,
  parameter int n_mant = 20,
  parameter int OUT_W = n_int + n_mant,
  parameter int N = Coefficients_Fx::N,
  parameter logic [N-1:0][Lookahead-1:0][OUT_W-1:0] hf = Coefficients_Fx::hf,
  parameter logic [N-1:0][Lookback-1:0][OUT_W-1:0] hb = Coefficients_Fx::hb
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     in,
  output logic [OUT_W-1:0] out,
  output logic             valid
);
  localparam int D = Lookahead + Lookback;
  localparam int AW = OUT_W + $clog2(D * N) + 1;
  localparam int FW = $clog2(D + 1);
  localparam int CW = OSR > 1 ? $clog2(OSR) : 1;
  localparam logic signed [AW-1:0] MAXV = {{(AW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [AW-1:0] MINV = ~MAXV;
  logic [D-2:0][N-1:0] b;
  logic [D-1:0][N-1:0] w;
  logic [FW-1:0] fill, fill_nxt;
  logic [CW-1:0] cnt;
  logic signed [AW-1:0] acc;
  logic [OUT_W-1:0] sat;
  logic load;
  // w is the buffer as it stands after this edge: w[0] = in, w[k] = b[k-1]
  assign w = {b, in};
  always_comb begin
    acc = '0;
    for (int c = 0; c < N; c++) begin
      for (int i = 0; i < Lookahead; i++)
        acc += w[Lookahead-1-i][c] ? AW'($signed(hf[c][i])) : -AW'($signed(hf[c][i]));
      for (int i = 0; i < Lookback; i++)
        acc += w[Lookahead+i][c] ? AW'($signed(hb[c][i])) : -AW'($signed(hb[c][i]));
    end
    sat = acc > MAXV ? {1'b0, {(OUT_W-1){1'b1}}} :
          acc < MINV ? {1'b1, {(OUT_W-1){1'b0}}} : acc[OUT_W-1:0];
    fill_nxt = fill == FW'(D) ? fill : fill + 1'b1;
    load = cnt == CW'(OSR - 1) && fill_nxt == FW'(D);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      b <= '0;
      fill <= '0;
      cnt <= '0;
      out <= '0;
      valid <= 1'b0;
    end else begin
      b <= w[D-2:0];
      fill <= fill_nxt;
      cnt <= cnt == CW'(OSR - 1) ? '0 : cnt + 1'b1;
      if (load) begin
        out <= {~sat[OUT_W-1], sat[OUT_W-2:0]};
        valid <= 1'b1;
      end
    end
endmodule

// File: tb/tb_fir_fixed_top.sv
// tb_fir_fixed_top: three small configurations driven in parallel against an input-history model.
module tb_fir_fixed_top;
  logic clk = 0, rst = 0;
  logic [0:0] in = 0;
  logic [5:0] o [3];
  logic v [3];
  int checks = 0, failures = 0;
  int e = 0;
  bit hist [$];
  int hfm [3][2] = '{'{8, 4}, '{8, 4}, '{16, 15}};
  int hbm [3][2] = '{'{8, 4}, '{8, 4}, '{16, 15}};
  int osrm [3] = '{1, 2, 1};
  int exp_out [3];
  bit exp_valid [3];

  fir_fixed_top #(.Lookahead(2), .Lookback(2), .OSR(1), .n_int(2), .n_mant(4), .N(1),
    .hf({6'd4, 6'd8}), .hb({6'd4, 6'd8})) u0 (.clk(clk), .rst(rst), .in(in), .out(o[0]), .valid(v[0]));
  fir_fixed_top #(.Lookahead(2), .Lookback(2), .OSR(2), .n_int(2), .n_mant(4), .N(1),
    .hf({6'd4, 6'd8}), .hb({6'd4, 6'd8})) u1 (.clk(clk), .rst(rst), .in(in), .out(o[1]), .valid(v[1]));
  fir_fixed_top #(.Lookahead(2), .Lookback(2), .OSR(1), .n_int(2), .n_mant(4), .N(1),
    .hf({6'd15, 6'd16}), .hb({6'd15, 6'd16})) u2 (.clk(clk), .rst(rst), .in(in), .out(o[2]), .valid(v[2]));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, want);
    end
  endtask

  function automatic int model_out(int k);
    int s = 0;
    for (int i = 0; i < 2; i++) begin
      s += (hist[1-i] ? 1 : -1) * hfm[k][i];
      s += (hist[2+i] ? 1 : -1) * hbm[k][i];
    end
    s = s > 31 ? 31 : s < -32 ? -32 : s;
    return s + 32;
  endfunction

  task automatic model_reset();
    hist.delete();
    e = 0;
    for (int k = 0; k < 3; k++) begin
      exp_out[k] = 0;
      exp_valid[k] = 0;
    end
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("%s_out%0d_e%0d", tag, k, e), 32'(o[k]), 32'(exp_out[k]));
      check($sformatf("%s_valid%0d_e%0d", tag, k, e), 32'(v[k]), 32'(exp_valid[k]));
    end
  endtask

  task automatic tick(input string tag, input bit x);
    in = x;
    @(posedge clk);
    hist.push_front(x);
    e++;
    for (int k = 0; k < 3; k++)
      if (e >= 4 && e % osrm[k] == 0) begin
        exp_out[k] = model_out(k);
        exp_valid[k] = 1;
      end
    #1;
    check_all(tag);
  endtask

  initial begin
    model_reset();
    repeat (2) begin
      @(posedge clk);
      #1;
      check_all("in_reset");
    end
    @(negedge clk);
    rst = 1;
    for (int t = 0; t < 6; t++) begin
      tick("fill", 1);
      if (t == 3) begin
        check("fill_first_out", 32'(o[0]), 32'd56);
        check("osr2_first_out", 32'(o[1]), 32'd56);
        check("sat_high", 32'(o[2]), 32'd63);
      end
    end
    for (int t = 0; t < 8; t++) tick("zeros", 0);
    check("zeros_out", 32'(o[0]), 32'd8);
    check("sat_low", 32'(o[2]), 32'd0);
    for (int t = 0; t < 8; t++) tick("impulse", t == 3);
    for (int t = 0; t < 10; t++) tick("alt", t % 2 == 0);
    for (int t = 0; t < 300; t++) tick("rand", 1'($urandom_range(0, 1)));
    #2;
    rst = 0;
    #1;
    model_reset();
    check_all("mid_reset");
    @(negedge clk);
    rst = 1;
    for (int t = 0; t < 40; t++) tick("refill", 1'($urandom_range(0, 1)));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
